// File: rtl/shift_unit_seq.sv
// Multi-cycle shift/rotate unit: SRA, RRC, LSR, LSL on a word or low-byte lane,
// up to STEP bits per cycle, producing {V,N,Z,C}.
module shift_unit_seq #(
  parameter int unsigned WORD = 16,
  parameter int unsigned STEP = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [1:0]              op,
  input  logic                    byte_mode,
  input  logic [$clog2(WORD):0]   amount,
  input  logic [3:0]              status_in,
  input  logic [WORD-1:0]         in,
  output logic                    busy,
  output logic                    done,
  output logic [WORD-1:0]         out,
  output logic [3:0]              status_out
);

  localparam int unsigned AW = $clog2(WORD) + 1;
  localparam logic [AW-1:0] StepW = AW'(STEP);

  localparam logic [1:0] OpSra = 2'b00;
  localparam logic [1:0] OpRrc = 2'b01;
  localparam logic [1:0] OpLsl = 2'b11;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic            bm_q, bm_d;
  logic [WORD-1:0] val_q, val_d;
  logic            c_q, c_d;
  logic [AW-1:0]   rem_q, rem_d;
  logic [WORD-1:0] out_q, out_d;
  logic [3:0]      status_q, status_d;

  logic [AW-1:0]   k;
  logic [WORD-1:0] sh_v;
  logic            sh_c;
  logic            lane_zero;
  logic            lane_msb;

  // One 1-bit step on the active lane; returns {carry_out, value}. Bits above the
  // byte lane pass through untouched.
  function automatic logic [WORD:0] shift1(input logic [WORD-1:0] v, input logic c,
                                           input logic [1:0] o, input logic bm);
    logic [WORD-1:0] r;
    logic            co;
    logic            msb;
    logic            fill;
    msb = bm ? v[7] : v[WORD-1];
    case (o)
      OpSra:   fill = msb;
      OpRrc:   fill = c;
      default: fill = 1'b0;
    endcase
    if (o == OpLsl) begin
      co = msb;
      r  = bm ? {v[WORD-1:8], v[6:0], 1'b0} : {v[WORD-2:0], 1'b0};
    end else begin
      co = v[0];
      r  = bm ? {v[WORD-1:8], fill, v[7:1]} : {fill, v[WORD-1:1]};
    end
    return {co, r};
  endfunction

  always_comb begin
    k = (rem_q < StepW) ? rem_q : StepW;
    sh_v = val_q;
    sh_c = c_q;
    for (int unsigned i = 0; i < STEP; i++) begin
      if (i < 32'(k)) {sh_c, sh_v} = shift1(sh_v, sh_c, op_q, bm_q);
    end
    lane_zero = bm_q ? (sh_v[7:0] == 8'd0) : (sh_v == '0);
    lane_msb  = bm_q ? sh_v[7] : sh_v[WORD-1];
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    bm_d     = bm_q;
    val_d    = val_q;
    c_d      = c_q;
    rem_d    = rem_q;
    out_d    = out_q;
    status_d = status_q;
    case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (start) begin
          op_d  = op;
          bm_d  = byte_mode;
          val_d = in;
          c_d   = status_in[0];
          rem_d = amount;
          if (amount == '0) begin
            // Zero count is a pure pass-through of operand and flags.
            out_d    = in;
            status_d = status_in;
            state_d  = StDone;
          end else begin
            state_d = StShift;
          end
        end
      end
      StShift: begin
        val_d = sh_v;
        c_d   = sh_c;
        rem_d = rem_q - k;
        if (rem_d == '0) begin
          out_d    = sh_v;
          status_d = {1'b0, lane_msb, lane_zero, sh_c};
          state_d  = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      op_q     <= 2'b00;
      bm_q     <= 1'b0;
      val_q    <= '0;
      c_q      <= 1'b0;
      rem_q    <= '0;
      out_q    <= '0;
      status_q <= 4'b0000;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      bm_q     <= bm_d;
      val_q    <= val_d;
      c_q      <= c_d;
      rem_q    <= rem_d;
      out_q    <= out_d;
      status_q <= status_d;
    end
  end

  assign busy       = (state_q == StShift);
  assign done       = (state_q == StDone);
  assign out        = out_q;
  assign status_out = status_q;

endmodule

// File: tb/tb_shift_unit_seq.sv
// Directed bench for shift_unit_seq: a STEP=1 and a STEP=4 instance, WORD=16.
module tb_shift_unit_seq;

  localparam logic [1:0] SRA = 2'b00;
  localparam logic [1:0] RRC = 2'b01;
  localparam logic [1:0] LSR = 2'b10;
  localparam logic [1:0] LSL = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start1 = 1'b0;
  logic        start4 = 1'b0;
  logic [1:0]  op = 2'b00;
  logic        bm = 1'b0;
  logic [4:0]  amount = 5'd0;
  logic [3:0]  st = 4'b0000;
  logic [15:0] din = 16'h0000;

  logic        busy1, done1, busy4, done4;
  logic [15:0] out1, out4;
  logic [3:0]  stat1, stat4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  shift_unit_seq #(.WORD(16), .STEP(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .op(op), .byte_mode(bm), .amount(amount),
    .status_in(st), .in(din), .busy(busy1), .done(done1), .out(out1), .status_out(stat1)
  );

  shift_unit_seq #(.WORD(16), .STEP(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .op(op), .byte_mode(bm), .amount(amount),
    .status_in(st), .in(din), .busy(busy4), .done(done4), .out(out4), .status_out(stat4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input bit sel4, input logic [1:0] o, input logic b, input logic [4:0] n,
                       input logic [3:0] s, input logic [15:0] v);
    op = o; bm = b; amount = n; st = s; din = v;
    if (sel4) start4 = 1'b1;
    else start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    start4 = 1'b0;
  endtask

  // Cycles counted from the cycle right after the accepting edge.
  task automatic wait_done(input bit sel4, input int max, output int cyc, output int bcyc);
    cyc = 0;
    bcyc = 0;
    while (!(sel4 ? done4 : done1) && cyc < max) begin
      if (sel4 ? busy4 : busy1) bcyc++;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic run(input string tag, input bit sel4, input logic [1:0] o, input logic b,
                     input logic [4:0] n, input logic [3:0] s, input logic [15:0] v,
                     input logic [15:0] exp_out, input logic [3:0] exp_st, input int exp_cyc);
    int cyc, bc;
    issue(sel4, o, b, n, s, v);
    wait_done(sel4, exp_cyc + 5, cyc, bc);
    chk({tag, "_done"}, sel4 ? done4 : done1, 1);
    chk({tag, "_excl"}, sel4 ? busy4 : busy1, 0);
    chk({tag, "_lat"}, cyc, exp_cyc);
    chk({tag, "_busy"}, bc, exp_cyc);
    chk({tag, "_out"}, sel4 ? out4 : out1, exp_out);
    chk({tag, "_st"}, sel4 ? stat4 : stat1, exp_st);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, sel4 ? done4 : done1, 0);
    chk({tag, "_hold"}, sel4 ? out4 : out1, exp_out);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc, bc;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_out", out1, 16'h0000);
    chk("rst_st", stat1, 4'b0000);
    chk("rst_out4", out4, 16'h0000);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // lsb shifted out of 0x8001 is 1, so C=1
    run("sra1", 1'b0, SRA, 1'b0, 5'd1, 4'b0000, 16'h8001, 16'hC000, 4'b0101, 1);
    run("rrc17", 1'b0, RRC, 1'b0, 5'd17, 4'b0001, 16'h1234, 16'h1234, 4'b0001, 17);
    run("rrc1", 1'b0, RRC, 1'b0, 5'd1, 4'b0000, 16'h0001, 16'h0000, 4'b0011, 1);
    run("lslb", 1'b0, LSL, 1'b1, 5'd1, 4'b0000, 16'hAB81, 16'hAB02, 4'b0001, 1);
    run("lsr20", 1'b0, LSR, 1'b0, 5'd20, 4'b0000, 16'hFFFF, 16'h0000, 4'b0010, 20);
    run("n0", 1'b0, LSL, 1'b0, 5'd0, 4'b1011, 16'h5555, 16'h5555, 4'b1011, 0);
    run("srab9", 1'b0, SRA, 1'b1, 5'd9, 4'b0000, 16'h1280, 16'h12FF, 4'b0101, 9);
    run("lsl16", 1'b0, LSL, 1'b0, 5'd16, 4'b0000, 16'h0001, 16'h0000, 4'b0011, 16);
    run("rrcb2", 1'b0, RRC, 1'b1, 5'd2, 4'b0001, 16'hFF01, 16'hFFC0, 4'b0100, 2);
    run("step4", 1'b1, LSR, 1'b0, 5'd6, 4'b0000, 16'hF000, 16'h03C0, 4'b0000, 2);

    // Reset in the middle of a shift abandons it.
    issue(1'b0, LSL, 1'b0, 5'd10, 4'b0000, 16'h0001);
    repeat (3) @(posedge clk);
    #1;
    chk("mid_busy", busy1, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mid_rst_busy", busy1, 0);
    chk("mid_rst_done", done1, 0);
    chk("mid_rst_out", out1, 16'h0000);
    chk("mid_rst_st", stat1, 4'b0000);
    wait_done(1'b0, 15, cyc, bc);
    chk("mid_nodone", done1, 0);
    chk("mid_nobusy", bc, 0);

    // A start pulse while shifting is ignored.
    issue(1'b0, LSR, 1'b0, 5'd4, 4'b0000, 16'h8000);
    @(posedge clk); #1;
    op = LSL; amount = 5'd1; din = 16'h0001; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    wait_done(1'b0, 10, cyc, bc);
    chk("ign_done", done1, 1);
    chk("ign_lat", cyc + 2, 4);
    chk("ign_out", out1, 16'h0800);
    chk("ign_st", stat1, 4'b0000);

    // Start held during DONE is accepted back-to-back.
    op = LSR; bm = 1'b0; amount = 5'd2; st = 4'b0000; din = 16'h0010; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    chk("b2b_busy", busy1, 1);
    chk("b2b_done_low", done1, 0);
    wait_done(1'b0, 10, cyc, bc);
    chk("b2b_done", done1, 1);
    chk("b2b_lat", cyc, 2);
    chk("b2b_out", out1, 16'h0004);
    chk("b2b_st", stat1, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
